clock_time_cnt: RTL and testbench

- Timekeeping stage directly downstream of ctrl_gen in the clock design.
- Divides the 100 MHz system clock into a 1 Hz time base and produces the mask_1hz blink signal that ctrl_gen consumes.
- Applies ctrl_gen's hour_inc / min_inc / sec_rst pulses to BCD hour/min/sec counters.
- Outputs feed the 7-segment display formatter.

---
 rtl/clock_time_cnt.sv | 120 ++++++++++++
 tb/tb_clock_time_cnt.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_cnt.sv
// Timekeeping stage: divides the system clock down to a 1 Hz tick and blink mask,
// and keeps BCD hour/min/sec counters driven by the tick and ctrl_gen's set pulses.
module clock_time_cnt #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int HALF     = CLK_FREQ / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hour_inc,
    input  logic       min_inc,
    input  logic       sec_rst,
    output logic       en_1hz,
    output logic       mask_1hz,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] TERM_CNT = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] HALF_CNT = PW'(HALF);

    logic [PW-1:0] presc_q, presc_d;
    logic          en_q, en_d;
    logic          mask_q, mask_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    hour_q, hour_d;

    logic tick;
    logic sec_carry;
    logic min_step;
    logic min_carry;
    logic hour_step;

    // Two-digit BCD increment wrapping 59 -> 00.
    function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Two-digit BCD increment wrapping 23 -> 00.
    function automatic logic [7:0] bcd_inc_24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        tick      = (presc_q == TERM_CNT);
        // sec_rst overrides the tick, so a coincident 59 produces no minute carry.
        sec_carry = tick && !sec_rst && (sec_q == 8'h59);
        min_step  = min_inc || sec_carry;
        min_carry = sec_carry && (min_q == 8'h59);
        hour_step = hour_inc || min_carry;

        presc_d = presc_q + PW'(1);
        if (sec_rst || tick) begin
            presc_d = '0;
        end

        en_d   = tick;
        mask_d = (presc_q >= HALF_CNT);

        sec_d = sec_q;
        if (sec_rst) begin
            sec_d = 8'h00;
        end else if (tick) begin
            sec_d = bcd_inc_60(sec_q);
        end

        min_d = min_q;
        if (min_step) begin
            min_d = bcd_inc_60(min_q);
        end

        hour_d = hour_q;
        if (hour_step) begin
            hour_d = bcd_inc_24(hour_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            en_q    <= 1'b0;
            mask_q  <= 1'b0;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= 8'h00;
        end else begin
            presc_q <= presc_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
        end
    end

    assign en_1hz   = en_q;
    assign mask_1hz = mask_q;
    assign sec_bcd  = sec_q;
    assign min_bcd  = min_q;
    assign hour_bcd = hour_q;

endmodule

// File: tb/tb_clock_time_cnt.sv
// Bench for clock_time_cnt with a small clock frequency: table vectors, directed
// corner sequences and random pulses checked against an integer time-of-day model.
module tb_clock_time_cnt;

    localparam int CF = 10;
    localparam int HF = CF / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hour_inc = 1'b0;
    logic       min_inc = 1'b0;
    logic       sec_rst = 1'b0;
    logic       en_1hz;
    logic       mask_1hz;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;

    clock_time_cnt #(.CLK_FREQ(CF), .HALF(HF)) dut (
        .clk      (clk),
        .rst      (rst),
        .hour_inc (hour_inc),
        .min_inc  (min_inc),
        .sec_rst  (sec_rst),
        .en_1hz   (en_1hz),
        .mask_1hz (mask_1hz),
        .sec_bcd  (sec_bcd),
        .min_bcd  (min_bcd),
        .hour_bcd (hour_bcd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers for time of day and the prescaler phase.
    int   m_presc, m_sec, m_min, m_hour;
    logic m_en, m_mask;

    typedef struct {
        logic       hi;
        logic       mi;
        logic       sr;
        int         n;
        logic [7:0] e_hour;
        logic [7:0] e_min;
        logic [7:0] e_sec;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r = {4'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_sec   = 0;
        m_min   = 0;
        m_hour  = 0;
        m_en    = 1'b0;
        m_mask  = 1'b0;
    endtask

    task automatic model_clock(input logic hi, input logic mi, input logic sr);
        bit tick, sc, mc;
        tick   = (m_presc == CF - 1);
        m_en   = tick;
        m_mask = (m_presc >= HF);
        sc = 1'b0;
        mc = 1'b0;
        if (sr) begin
            m_presc = 0;
            m_sec   = 0;
        end else if (tick) begin
            m_presc = 0;
            sc      = (m_sec == 59);
            m_sec   = (m_sec + 1) % 60;
        end else begin
            m_presc = m_presc + 1;
        end
        if (mi || sc) begin
            mc    = sc && (m_min == 59);
            m_min = (m_min + 1) % 60;
        end
        if (hi || mc) begin
            m_hour = (m_hour + 1) % 24;
        end
    endtask

    task automatic compare_all();
        check8("en_1hz", {7'b0, en_1hz}, {7'b0, m_en});
        check8("mask_1hz", {7'b0, mask_1hz}, {7'b0, m_mask});
        check8("sec_bcd", sec_bcd, to_bcd(m_sec));
        check8("min_bcd", min_bcd, to_bcd(m_min));
        check8("hour_bcd", hour_bcd, to_bcd(m_hour));
    endtask

    // Called at posedge+1; drives inputs, advances one edge, checks at posedge+1.
    task automatic step(input logic hi, input logic mi, input logic sr);
        hour_inc = hi;
        min_inc  = mi;
        sec_rst  = sr;
        @(posedge clk);
        if (rst) model_reset();
        else     model_clock(hi, mi, sr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after one edge.
    task automatic do_reset();
        hour_inc = 1'b0;
        min_inc  = 1'b0;
        sec_rst  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check8("rst_en", {7'b0, en_1hz}, 8'h00);
        check8("rst_mask", {7'b0, mask_1hz}, 8'h00);
        check8("rst_sec", sec_bcd, 8'h00);
        check8("rst_min", min_bcd, 8'h00);
        check8("rst_hour", hour_bcd, 8'h00);
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic expect_time(input string name, input logic [7:0] h, input logic [7:0] m,
                               input logic [7:0] s);
        check8({name, "_hour"}, hour_bcd, h);
        check8({name, "_min"}, min_bcd, m);
        check8({name, "_sec"}, sec_bcd, s);
    endtask

    // Counts edges until the first en_1hz, bounded at 20.
    task automatic first_en_after(input string name, input int exp);
        int found;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (en_1hz && found == 0) found = k;
        end
        check_int(name, found, exp);
    endtask

    initial begin
        int en_count, last_en, first_mask, mask_high;

        tbl[0] = '{hi: 1'b1, mi: 1'b0, sr: 1'b1, n: 23, e_hour: 8'h23, e_min: 8'h00, e_sec: 8'h00};
        tbl[1] = '{hi: 1'b1, mi: 1'b0, sr: 1'b1, n: 1,  e_hour: 8'h00, e_min: 8'h00, e_sec: 8'h00};
        tbl[2] = '{hi: 1'b0, mi: 1'b1, sr: 1'b1, n: 59, e_hour: 8'h00, e_min: 8'h59, e_sec: 8'h00};
        tbl[3] = '{hi: 1'b0, mi: 1'b1, sr: 1'b1, n: 1,  e_hour: 8'h00, e_min: 8'h00, e_sec: 8'h00};
        tbl[4] = '{hi: 1'b1, mi: 1'b1, sr: 1'b1, n: 5,  e_hour: 8'h05, e_min: 8'h05, e_sec: 8'h00};
        tbl[5] = '{hi: 1'b0, mi: 1'b0, sr: 1'b0, n: 25, e_hour: 8'h05, e_min: 8'h05, e_sec: 8'h02};

        model_reset();
        @(posedge clk);
        #1;

        // Free run
        do_reset();
        en_count   = 0;
        last_en    = 0;
        first_mask = 0;
        mask_high  = 0;
        for (int c = 1; c <= 125; c++) begin
            step(1'b0, 1'b0, 1'b0);
            if (en_1hz) begin
                en_count++;
                if (last_en > 0) check_int("en_period", c - last_en, CF);
                last_en = c;
            end
            if (mask_1hz) begin
                mask_high++;
                if (first_mask == 0) first_mask = c;
            end
        end
        check_int("en_count", en_count, 12);
        check_int("mask_first_rise", first_mask, HF + 1);
        check_int("mask_high_cycles", mask_high, 60);
        expect_time("free_run", 8'h00, 8'h00, 8'h12);

        // Table vectors: hour wrap, minute wrap, combined pulses, idle ticks
        do_reset();
        for (int i = 0; i < 6; i++) begin
            repeat (tbl[i].n) step(tbl[i].hi, tbl[i].mi, tbl[i].sr);
            expect_time($sformatf("vec%0d", i), tbl[i].e_hour, tbl[i].e_min, tbl[i].e_sec);
        end

        // Full rollover 23:59:59 -> 00:00:00
        do_reset();
        repeat (23) step(1'b1, 1'b0, 1'b1);
        repeat (59) step(1'b0, 1'b1, 1'b1);
        idle(599);
        expect_time("pre_roll", 8'h23, 8'h59, 8'h59);
        step(1'b0, 1'b0, 1'b0);
        expect_time("rollover", 8'h00, 8'h00, 8'h00);

        // sec_rst mid-second restarts the prescaler
        do_reset();
        idle(17);
        expect_time("pre_secrst", 8'h00, 8'h00, 8'h01);
        step(1'b0, 1'b0, 1'b1);
        expect_time("secrst", 8'h00, 8'h00, 8'h00);
        first_en_after("secrst_en_delay", CF);

        // min_inc coincident with the minute carry, then sec_rst on a tick at 59
        do_reset();
        repeat (10) step(1'b0, 1'b1, 1'b1);
        idle(599);
        expect_time("pre_coinc", 8'h00, 8'h10, 8'h59);
        step(1'b0, 1'b1, 1'b0);
        expect_time("coinc_min_inc", 8'h00, 8'h11, 8'h00);
        idle(599);
        expect_time("pre_secrst_tick", 8'h00, 8'h11, 8'h59);
        step(1'b0, 1'b0, 1'b1);
        expect_time("secrst_tick", 8'h00, 8'h11, 8'h00);

        // Asynchronous reset at 12:34:56
        do_reset();
        repeat (12) step(1'b1, 1'b0, 1'b1);
        repeat (34) step(1'b0, 1'b1, 1'b1);
        idle(560);
        expect_time("pre_async", 8'h12, 8'h34, 8'h56);
        do_reset();
        first_en_after("async_rst_en_delay", CF);

        // Random pulses against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
